// File: rtl/seven_seg_temp_mux.sv
// Multiplexed 7-segment display of a signed temperature x100, converted serially by double-dabble.
// Define SEVSEG_LZ_BLANK_EN to blank leading zeros and float the minus sign next to the leading digit.
module seven_seg_temp_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int FRAC_DIGITS = 2,
    parameter int SCAN_DIV    = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [31:0]      i_temp_x100,
    input  logic                    i_temp_valid,
    output logic                    o_busy,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an
);
    // state  | meaning
    // IDLE   | waiting for a sample, display regs stable
    // SHIFT  | 32 double-dabble steps, one magnitude bit per clock
    // COMMIT | latch shown digits, sign and overflow into display regs
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    localparam int IW    = $clog2(NUM_DIGITS);
    localparam int PW    = $clog2(SCAN_DIV);
    localparam int LO    = 2 - FRAC_DIGITS;
    localparam int SHOWN = 8 + FRAC_DIGITS;
    localparam logic [6:0] P_MINUS = 7'b0111111;
    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    state_t r_state, w_next;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [39:0] r_bcd, w_adj;
    logic [4:0]  r_cnt;
    logic [3:0]  r_dig [NUM_DIGITS];
    logic        r_neg, r_ovf;
    logic        w_nz, w_neg, w_ovf;
    logic [PW-1:0] r_pre;
    logic [IW-1:0] r_idx;
    logic [3:0]  w_idx4;
    logic [6:0]  w_pat;
    logic        w_dpon;
    logic [NUM_DIGITS-1:0] w_onehot;
`ifdef SEVSEG_LZ_BLANK_EN
    logic [3:0]  w_msd;
`endif

    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        case (d)
            4'd0:    digit_pat = 7'b1000000;
            4'd1:    digit_pat = 7'b1111001;
            4'd2:    digit_pat = 7'b0100100;
            4'd3:    digit_pat = 7'b0110000;
            4'd4:    digit_pat = 7'b0011001;
            4'd5:    digit_pat = 7'b0010010;
            4'd6:    digit_pat = 7'b0000010;
            4'd7:    digit_pat = 7'b1111000;
            4'd8:    digit_pat = 7'b0000000;
            4'd9:    digit_pat = 7'b0010000;
            default: digit_pat = P_BLANK;
        endcase
    endfunction

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_temp_valid) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == 5'd0) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int n = 0; n < 10; n++)
            if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end

    // Truncated x100 digits below the shown range never affect sign or overflow.
    always_comb begin
        w_nz  = |r_bcd[39:4*LO];
        w_neg = r_sign & w_nz;
        w_ovf = 1'b0;
        for (int j = 0; j < SHOWN; j++)
            if ((j >= NUM_DIGITS - int'(w_neg)) && (r_bcd[4*(j+LO) +: 4] != 4'd0)) w_ovf = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
            for (int j = 0; j < NUM_DIGITS; j++) r_dig[j] <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (i_temp_valid) begin
                    r_sign <= i_temp_x100[31];
                    r_mag  <= i_temp_x100[31] ? (~$unsigned(i_temp_x100) + 32'd1) : $unsigned(i_temp_x100);
                    r_bcd  <= '0;
                    r_cnt  <= 5'd31;
                end
                S_SHIFT: begin
                    {r_bcd, r_mag} <= {w_adj[38:0], r_mag, 1'b0};
                    r_cnt          <= r_cnt - 5'd1;
                end
                S_COMMIT: begin
                    r_neg <= w_neg;
                    r_ovf <= w_ovf;
                    for (int j = 0; j < NUM_DIGITS; j++) r_dig[j] <= r_bcd[4*(j+LO) +: 4];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PW'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_comb begin
        w_idx4 = 4'(r_idx);
        w_pat  = digit_pat(r_dig[r_idx]);
        w_dpon = (FRAC_DIGITS > 0) && (w_idx4 == 4'(FRAC_DIGITS));
`ifdef SEVSEG_LZ_BLANK_EN
        w_msd = 4'(FRAC_DIGITS);
        for (int j = FRAC_DIGITS; j < NUM_DIGITS; j++)
            if (r_dig[j] != 4'd0) w_msd = 4'(j);
`endif
        if (r_ovf) begin
            w_pat  = P_MINUS;
            w_dpon = 1'b0;
        end else begin
`ifdef SEVSEG_LZ_BLANK_EN
            if (w_idx4 > w_msd) w_pat = (r_neg && (w_idx4 == w_msd + 4'd1)) ? P_MINUS : P_BLANK;
`else
            if (r_neg && (w_idx4 == 4'(NUM_DIGITS - 1))) w_pat = P_MINUS;
`endif
        end
        w_onehot = NUM_DIGITS'(1) << r_idx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_seg <= SEG_OFF;
            o_dp  <= DP_OFF;
            o_an  <= AN_OFF;
        end else begin
            o_seg <= (ACTIVE_LOW != 0) ? w_pat : ~w_pat;
            o_dp  <= (ACTIVE_LOW != 0) ? ~w_dpon : w_dpon;
            o_an  <= (ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
        end
    end
endmodule
